maxnet_feeder: RTL and testbench

- Upstream sequencer for Maxnet, the 4-input winner-take-all block.
- Accepts a serial stream of 5-bit activations over a valid/ready handshake, packs four of them into X1..X4, and pulses start.
- Waits for Maxnet's done, captures result, and presents it downstream over a valid/ready handshake.
- A watchdog flags a Maxnet run that never completes.

---
 rtl/maxnet_pkg.sv | 15 +
 rtl/maxnet_watchdog.sv | 31 +++
 rtl/maxnet_feeder.sv | 128 ++++++++++++
 tb/tb_maxnet_feeder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxnet_pkg.sv
// Shared constants and state encoding for the Maxnet feeder.
// Sample width and slot count are fixed by Maxnet's port list.
package maxnet_pkg;

    localparam int WIDTH  = 5;
    localparam int NUM_IN = 4;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/maxnet_watchdog.sv
// Saturating run-length counter for a single Maxnet run.
// expire is asserted on the cycle the count would reach TIMEOUT.
module maxnet_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign expire = en && (count >= LAST);

endmodule

// File: rtl/maxnet_feeder.sv
// Packs four streamed activations for Maxnet, launches a run and
// hands the winner (or a timeout marker) downstream.
module maxnet_feeder
    import maxnet_pkg::*;
#(
    parameter int WIDTH   = maxnet_pkg::WIDTH,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] X1,
    output logic [WIDTH-1:0] X2,
    output logic [WIDTH-1:0] X3,
    output logic [WIDTH-1:0] X4,
    output logic             start,
    input  logic             done,
    input  logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_timeout,
    input  logic             out_ready
);

    localparam int CW = $clog2(NUM_IN);
    localparam logic [CW-1:0] LAST_SLOT = CW'(NUM_IN - 1);

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    cnt;
    logic             done_q;
    logic             rise_q;
    logic [WIDTH-1:0] result_q;
    logic             accept;
    logic             wd_clr;
    logic             wd_en;
    logic             expire;
    logic             cap;
    logic             tmo;

    assign in_ready = rst & (state == LOAD);
    assign accept   = in_valid & in_ready;

    maxnet_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wd (
        .clk   (clk),
        .rst   (rst),
        .clr   (wd_clr),
        .en    (wd_en),
        .expire(expire)
    );

    always_comb begin
        state_n = state;
        wd_clr  = 1'b0;
        wd_en   = 1'b0;
        cap     = 1'b0;
        tmo     = 1'b0;
        unique case (state)
            LOAD: begin
                if (accept && cnt == LAST_SLOT) state_n = START;
            end
            START: begin
                wd_clr  = 1'b1;
                state_n = WAIT;
            end
            WAIT: begin
                wd_en = 1'b1;
                // a done edge beats a simultaneous expiry
                if (rise_q) begin
                    cap     = 1'b1;
                    state_n = OUT;
                end else if (expire) begin
                    tmo     = 1'b1;
                    state_n = OUT;
                end
            end
            OUT: begin
                if (out_ready) state_n = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= LOAD;
            cnt         <= '0;
            X1          <= '0;
            X2          <= '0;
            X3          <= '0;
            X4          <= '0;
            start       <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_timeout <= 1'b0;
            done_q      <= 1'b0;
            rise_q      <= 1'b0;
            result_q    <= '0;
        end else begin
            state     <= state_n;
            done_q    <= done;
            rise_q    <= done & ~done_q;
            result_q  <= result;
            start     <= (state_n == START);
            out_valid <= (state_n == OUT);
            if (accept) begin
                unique case (cnt)
                    2'd0: X1 <= in_data;
                    2'd1: X2 <= in_data;
                    2'd2: X3 <= in_data;
                    2'd3: X4 <= in_data;
                endcase
                cnt <= (cnt == LAST_SLOT) ? '0 : cnt + 1'b1;
            end
            if (cap) begin
                out_data    <= result_q;
                out_timeout <= 1'b0;
            end else if (tmo) begin
                out_data    <= '0;
                out_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_maxnet_feeder.sv
// Directed bench for maxnet_feeder with a hand-timed Maxnet stand-in.
// Runs with TIMEOUT=16 so timeout paths are short.
module tb_maxnet_feeder;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic [W-1:0] X1, X2, X3, X4;
    logic         start;
    logic         done = 1'b0;
    logic [W-1:0] result = '0;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_timeout;
    logic         out_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int starts = 0;
    int s0;

    maxnet_feeder #(
        .WIDTH  (W),
        .TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .X1         (X1),
        .X2         (X2),
        .X3         (X3),
        .X4         (X4),
        .start      (start),
        .done       (done),
        .result     (result),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_timeout(out_timeout),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (start === 1'b1) starts <= starts + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] v);
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_x(input string tag, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] c,
                           input logic [W-1:0] d);
        check({tag, "_x1"}, 32'(X1), 32'(a));
        check({tag, "_x2"}, 32'(X2), 32'(b));
        check({tag, "_x3"}, 32'(X3), 32'(c));
        check({tag, "_x4"}, 32'(X4), 32'(d));
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_start", 32'(start), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_timeout", 32'(out_timeout), 0);
        check_x("rst", 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 1);

        // back-to-back load, done 10 cycles after start
        push(1);
        push(2);
        push(3);
        check("t1_no_start", 32'(start), 0);
        push(4);
        check("t1_start", 32'(start), 1);
        check_x("t1", 1, 2, 3, 4);
        tick();
        check("t1_start_end", 32'(start), 0);
        check("t1_wait_ready", 32'(in_ready), 0);
        repeat (9) tick();
        done   = 1'b1;
        result = 5'd4;
        tick();
        check("t1_ov_early", 32'(out_valid), 0);
        tick();
        check("t1_ov", 32'(out_valid), 1);
        check("t1_data", 32'(out_data), 4);
        check("t1_tmo", 32'(out_timeout), 0);
        check("t1_out_ready", 32'(in_ready), 0);
        consume();
        check("t1_back_load", 32'(in_ready), 1);
        check("t1_ov_clear", 32'(out_valid), 0);
        done   = 1'b0;
        result = '0;

        // gapped load, then a stalled consumer
        s0 = starts;
        push(7);
        repeat (3) begin tick(); check("t2_gap_start", 32'(start), 0); end
        push(0);
        repeat (3) begin tick(); check("t2_gap_start", 32'(start), 0); end
        push(31);
        repeat (3) begin tick(); check("t2_gap_start", 32'(start), 0); end
        push(5);
        check("t2_start", 32'(start), 1);
        check_x("t2", 7, 0, 31, 5);
        tick();
        check("t2_start_end", 32'(start), 0);
        tick();
        tick();
        done   = 1'b1;
        result = 5'd31;
        tick();
        tick();
        check("t2_ov", 32'(out_valid), 1);
        check("t2_data", 32'(out_data), 31);
        repeat (20) begin
            tick();
            check("t3_hold_ov", 32'(out_valid), 1);
            check("t3_hold_data", 32'(out_data), 31);
            check("t3_hold_ready", 32'(in_ready), 0);
        end
        check_x("t3_hold", 7, 0, 31, 5);
        check("t2_one_start", 32'(starts - s0), 1);
        consume();
        check("t3_release_ready", 32'(in_ready), 1);
        check("t3_release_ov", 32'(out_valid), 0);
        done = 1'b0;

        // no done at all: expiry after 16 wait cycles
        push(3);
        push(6);
        push(9);
        push(12);
        check("t4_start", 32'(start), 1);
        repeat (16) tick();
        check("t4_ov_early", 32'(out_valid), 0);
        tick();
        check("t4_ov", 32'(out_valid), 1);
        check("t4_data", 32'(out_data), 0);
        check("t4_tmo", 32'(out_timeout), 1);
        consume();

        // done held over from before start
        done   = 1'b1;
        result = 5'd2;
        tick();
        tick();
        push(1);
        push(1);
        push(1);
        push(1);
        check("t5_start", 32'(start), 1);
        repeat (5) tick();
        check("t5_stale_done", 32'(out_valid), 0);
        done = 1'b0;
        tick();
        done   = 1'b1;
        result = 5'd9;
        tick();
        check("t5_ov_early", 32'(out_valid), 0);
        tick();
        check("t5_ov", 32'(out_valid), 1);
        check("t5_data", 32'(out_data), 9);
        check("t5_tmo", 32'(out_timeout), 0);
        consume();
        done = 1'b0;

        // done edge on the expiry cycle
        push(2);
        push(4);
        push(6);
        push(8);
        check("t5b_start", 32'(start), 1);
        repeat (15) tick();
        done   = 1'b1;
        result = 5'd17;
        tick();
        check("t5b_ov_early", 32'(out_valid), 0);
        tick();
        check("t5b_ov", 32'(out_valid), 1);
        check("t5b_data", 32'(out_data), 17);
        check("t5b_tmo", 32'(out_timeout), 0);
        consume();
        done = 1'b0;

        // reset in WAIT, then reset over a partial batch
        push(21);
        push(22);
        push(23);
        push(24);
        check("t6_start", 32'(start), 1);
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        check_x("t6_async", 0, 0, 0, 0);
        check("t6_start0", 32'(start), 0);
        check("t6_ready0", 32'(in_ready), 0);
        check("t6_ov0", 32'(out_valid), 0);
        check("t6_data0", 32'(out_data), 0);
        check("t6_tmo0", 32'(out_timeout), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        push(10);
        push(11);
        #2 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        s0 = starts;
        push(12);
        check("t6_first_slot", 32'(X1), 12);
        push(13);
        push(14);
        check("t6_no_start", 32'(start), 0);
        push(15);
        check("t6_start_after4", 32'(start), 1);
        check_x("t6", 12, 13, 14, 15);
        tick();
        check("t6_one_start", 32'(starts - s0), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
